alsu_cmd_arbiter: RTL and testbench

Shares one registered ALSU datapath between two command requesters. Each requester submits a packed 16-bit command over a valid/ready handshake. The block grants requesters round-robin and drives the ALSU input bus for exactly one cycle per command. It captures the 6-bit ALSU result after a fixed latency and returns it, with the requester ID and an invalid-command flag, as a one-cycle response pulse. It sits between the switch/host command sources and the ALSU instance, upstream of the LED/7-segment display logic.

---
 rtl/alsu_arb_pkg.sv | 53 +++++
 rtl/rr_arbiter_2.sv | 41 ++++
 rtl/alsu_cmd_arbiter.sv | 128 ++++++++++++
 tb/tb_alsu_cmd_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_arb_pkg.sv
// rtl/alsu_arb_pkg.sv - shared types, opcodes and command checks for the ALSU command arbiter
package alsu_arb_pkg;

   localparam int CMD_W = 16;
   localparam int FIELD_W = 3;
   localparam int RES_W = 6;
   localparam int CNT_W = 8;

   // Field layout of the packed 16-bit ALSU command, msb first
   typedef struct packed {
      logic [FIELD_W-1:0] opcode;     // [15:13]
      logic [FIELD_W-1:0] a;          // [12:10]
      logic [FIELD_W-1:0] b;          // [9:7]
      logic               cin;        // [6]
      logic               serial_in;  // [5]
      logic               red_op_a;   // [4]
      logic               red_op_b;   // [3]
      logic               bypass_a;   // [2]
      logic               bypass_b;   // [1]
      logic               direction;  // [0]
   } alsu_cmd_t;

   localparam logic [FIELD_W-1:0] OP_AND    = 3'b000;
   localparam logic [FIELD_W-1:0] OP_XOR    = 3'b001;
   localparam logic [FIELD_W-1:0] OP_ADD    = 3'b010;
   localparam logic [FIELD_W-1:0] OP_MUL    = 3'b011;
   localparam logic [FIELD_W-1:0] OP_SHIFT  = 3'b100;
   localparam logic [FIELD_W-1:0] OP_ROTATE = 3'b101;
   localparam logic [FIELD_W-1:0] OP_INV0   = 3'b110;
   localparam logic [FIELD_W-1:0] OP_INV1   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Reserved opcodes are illegal; reduction flags are only meaningful for AND/XOR
   function automatic logic is_invalid(input logic [CMD_W-1:0] cmd);
      alsu_cmd_t c;
      logic      inv;
      c = cmd;
      case (c.opcode)
         OP_AND, OP_XOR:                       inv = 1'b0;
         OP_ADD, OP_MUL, OP_SHIFT, OP_ROTATE:  inv = c.red_op_a | c.red_op_b;
         OP_INV0, OP_INV1:                     inv = 1'b1;
         default:                              inv = 1'b1;
      endcase
      return inv;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin grant with pointer update enable
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update_en,
   output logic [1:0] gnt
);

   // ptr_q names the requester favoured on the next grant
   logic ptr_q;
   logic ptr_d;

   // Grant the favoured requester if it asks, otherwise the other one
   always_comb begin
      gnt = 2'b00;
      if (req[ptr_q]) begin
         gnt[ptr_q] = 1'b1;
      end else if (req[~ptr_q]) begin
         gnt[~ptr_q] = 1'b1;
      end
   end

   // After a committed grant, favour the requester that did not win
   always_comb begin
      ptr_d = ptr_q;
      if (update_en && (gnt != 2'b00)) begin
         ptr_d = gnt[0];
      end
   end

   // Pointer register; reset favours requester 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alsu_cmd_arbiter.sv
// rtl/alsu_cmd_arbiter.sv - shares one registered ALSU between two command requesters
module alsu_cmd_arbiter
   import alsu_arb_pkg::*;
#(
   parameter int               ALSU_LAT = 2,
   parameter logic [CMD_W-1:0] IDLE_CMD = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   input  logic [CMD_W-1:0] req_cmd0,
   input  logic [CMD_W-1:0] req_cmd1,
   output logic [1:0]       req_ready,
   output logic [CMD_W-1:0] alsu_cmd,
   input  logic [RES_W-1:0] alsu_out,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [RES_W-1:0] rsp_data,
   output logic             rsp_invalid,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] invalid_count
);

   localparam int WAIT_W = 3;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALSU_LAT - 1);

   arb_state_e       state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             rsp_id_q, rsp_id_d;
   logic [RES_W-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_invalid_q, rsp_invalid_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic [CNT_W-1:0] invalid_count_q, invalid_count_d;

   logic [1:0] gnt;
   logic       accept;

   // A grant only commits while idle; the pointer must not move otherwise
   assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);

   rr_arbiter_2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .update_en (accept),
      .gnt       (gnt)
   );

   // Next-state, datapath updates and bus outputs for IDLE -> ISSUE -> WAIT -> RESP
   always_comb begin
      state_d         = state_q;
      cmd_d           = cmd_q;
      wait_cnt_d      = wait_cnt_q;
      rsp_id_d        = rsp_id_q;
      rsp_data_d      = rsp_data_q;
      rsp_invalid_d   = rsp_invalid_q;
      op_count_d      = op_count_q;
      invalid_count_d = invalid_count_q;
      req_ready       = 2'b00;
      alsu_cmd        = IDLE_CMD;
      case (state_q)
         ST_IDLE: begin
            req_ready = gnt;
            if (accept) begin
               cmd_d    = gnt[1] ? req_cmd1 : req_cmd0;
               rsp_id_d = gnt[1];
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alsu_cmd   = cmd_q;
            wait_cnt_d = WAIT_LAST;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == '0) begin
               rsp_data_d    = alsu_out;
               rsp_invalid_d = is_invalid(cmd_q);
               state_d       = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            op_count_d = op_count_q + 1'b1;
            if (rsp_invalid_q && (invalid_count_q != '1)) begin
               invalid_count_d = invalid_count_q + 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight command
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cmd_q           <= IDLE_CMD;
         wait_cnt_q      <= '0;
         rsp_id_q        <= 1'b0;
         rsp_data_q      <= '0;
         rsp_invalid_q   <= 1'b0;
         op_count_q      <= '0;
         invalid_count_q <= '0;
      end else begin
         state_q         <= state_d;
         cmd_q           <= cmd_d;
         wait_cnt_q      <= wait_cnt_d;
         rsp_id_q        <= rsp_id_d;
         rsp_data_q      <= rsp_data_d;
         rsp_invalid_q   <= rsp_invalid_d;
         op_count_q      <= op_count_d;
         invalid_count_q <= invalid_count_d;
      end
   end

   assign rsp_valid     = (state_q == ST_RESP);
   assign busy          = (state_q != ST_IDLE);
   assign rsp_id        = rsp_id_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_invalid   = rsp_invalid_q;
   assign op_count      = op_count_q;
   assign invalid_count = invalid_count_q;

endmodule

// File: tb/tb_alsu_cmd_arbiter.sv
// tb/tb_alsu_cmd_arbiter.sv - scoreboard bench for alsu_cmd_arbiter with a behavioural ALSU
module tb_alsu_cmd_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_cmd0 = 16'h0;
   logic [15:0] req_cmd1 = 16'h0;
   logic [1:0]  req_ready;
   logic [15:0] alsu_cmd;
   logic [5:0]  alsu_out;
   logic        rsp_valid;
   logic        rsp_id;
   logic [5:0]  rsp_data;
   logic        rsp_invalid;
   logic        busy;
   logic [7:0]  op_count;
   logic [7:0]  invalid_count;

   always #5 clk = ~clk;

   alsu_cmd_arbiter #(.ALSU_LAT(LAT), .IDLE_CMD(16'h0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_cmd0      (req_cmd0),
      .req_cmd1      (req_cmd1),
      .req_ready     (req_ready),
      .alsu_cmd      (alsu_cmd),
      .alsu_out      (alsu_out),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_invalid   (rsp_invalid),
      .busy          (busy),
      .op_count      (op_count),
      .invalid_count (invalid_count)
   );

   // Behavioural two-stage ALSU: input register then output register
   function automatic logic [5:0] alsu_fn(input logic [15:0] c, input logic [5:0] o);
      logic [2:0] op, a, b;
      op = c[15:13];
      a  = c[12:10];
      b  = c[9:7];
      alsu_fn = 6'd0;
      if (op[2:1] == 2'b11 || ((c[4] | c[3]) && op[2:1] != 2'b00)) alsu_fn = 6'd0;
      else if (c[2]) alsu_fn = {3'b0, a};
      else if (c[1]) alsu_fn = {3'b0, b};
      else begin
         case (op)
            3'b000:  alsu_fn = c[4] ? {5'b0, &a} : c[3] ? {5'b0, &b} : {3'b0, a & b};
            3'b001:  alsu_fn = c[4] ? {5'b0, ^a} : c[3] ? {5'b0, ^b} : {3'b0, a ^ b};
            3'b010:  alsu_fn = {3'b0, a} + {3'b0, b} + {5'b0, c[6]};
            3'b011:  alsu_fn = {3'b0, a} * {3'b0, b};
            3'b100:  alsu_fn = c[0] ? {o[4:0], c[5]} : {c[5], o[5:1]};
            default: alsu_fn = c[0] ? {o[4:0], o[5]} : {o[0], o[5:1]};
         endcase
      end
   endfunction

   logic [15:0] alsu_in_q;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alsu_in_q <= 16'h0;
         alsu_out  <= 6'h0;
      end else begin
         alsu_in_q <= alsu_cmd;
         alsu_out  <= alsu_fn(alsu_in_q, alsu_out);
      end
   end

   typedef struct packed {
      logic [15:0] cmd;
      logic [5:0]  data;
      logic        inv;
   } vec_t;

   typedef struct {
      logic       id;
      logic [5:0] data;
      logic       inv;
      int         hs;
   } exp_t;

   vec_t q0[$];
   vec_t q1[$];
   exp_t expq[$];
   logic rsp_log[$];

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         hs_cyc = -1000;
   logic       exp_ptr = 1'b0;
   logic [7:0] exp_ops = 8'd0;
   logic [7:0] exp_inv = 8'd0;
   logic       cnt_pending = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic submit(input logic r, input logic [15:0] cmd, input logic [5:0] data, input logic inv);
      vec_t v;
      v.cmd  = cmd;
      v.data = data;
      v.inv  = inv;
      if (r) q1.push_back(v);
      else   q0.push_back(v);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst         = 1'b1;
      req_valid   = 2'b00;
      q0.delete();
      q1.delete();
      expq.delete();
      hs_cyc      = -1000;
      exp_ptr     = 1'b0;
      exp_ops     = 8'd0;
      exp_inv     = 8'd0;
      cnt_pending = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'(2'b00));
      chk("rst_alsu_cmd", 32'(alsu_cmd), 32'(16'h0000));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
      chk("rst_rsp_id", 32'(rsp_id), 32'(1'b0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(6'd0));
      chk("rst_rsp_invalid", 32'(rsp_invalid), 32'(1'b0));
      chk("rst_busy", 32'(busy), 32'(1'b0));
      chk("rst_op_count", 32'(op_count), 32'(8'd0));
      chk("rst_invalid_count", 32'(invalid_count), 32'(8'd0));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 3000), 32'(1));
      repeat (3) @(posedge clk);
      #3;
   endtask

   // Driver: checks grant/busy against a round-robin model and records expected responses
   initial begin : driver
      logic       exp_busy;
      logic [1:0] exp_rdy;
      logic [1:0] pop;
      vec_t       v;
      exp_t       e;
      forever begin
         @(negedge clk);
         exp_busy = (cyc > hs_cyc) && (cyc <= hs_cyc + LAT + 2);
         exp_rdy  = 2'b00;
         pop      = 2'b00;
         if (!exp_busy) begin
            if (req_valid[exp_ptr])       exp_rdy[exp_ptr] = 1'b1;
            else if (req_valid[!exp_ptr]) exp_rdy[!exp_ptr] = 1'b1;
         end
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (exp_rdy != 2'b00) begin
            v      = exp_rdy[1] ? q1[0] : q0[0];
            e.id   = exp_rdy[1];
            e.data = v.data;
            e.inv  = v.inv;
            e.hs   = cyc;
            expq.push_back(e);
            hs_cyc  = cyc;
            exp_ptr = ~exp_rdy[1];
            pop     = exp_rdy;
         end
         @(posedge clk);
         #1;
         if (pop[0] && q0.size() != 0) v = q0.pop_front();
         if (pop[1] && q1.size() != 0) v = q1.pop_front();
         req_valid = {q1.size() != 0, q0.size() != 0};
         req_cmd0  = (q0.size() != 0) ? q0[0].cmd : 16'h0;
         req_cmd1  = (q1.size() != 0) ? q1[0].cmd : 16'h0;
      end
   end

   // Monitor: pops the scoreboard on each response pulse and checks counters a cycle later
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (cnt_pending) begin
            chk("op_count", 32'(op_count), 32'(exp_ops));
            chk("invalid_count", 32'(invalid_count), 32'(exp_inv));
            cnt_pending = 1'b0;
         end
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", 32'(1), 32'(0));
            end else begin
               e = expq.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("rsp_invalid", 32'(rsp_invalid), 32'(e.inv));
               chk("rsp_latency", 32'(cyc - e.hs), 32'(LAT + 2));
               rsp_log.push_back(rsp_id);
               exp_ops = exp_ops + 8'd1;
               if (e.inv && exp_inv != 8'd255) exp_inv = exp_inv + 8'd1;
               cnt_pending = 1'b1;
            end
         end else if (expq.size() != 0 && cyc > expq[0].hs + LAT + 2) begin
            chk("rsp_missing", 32'(0), 32'(1));
            e = expq.pop_front();
         end
      end
   end

   initial begin : main
      int base;
      int n;
      apply_reset();

      // ADD 3+2 from requester 0
      submit(1'b0, 16'h4D00, 6'd5, 1'b0);
      drain();
      chk("single_op_count", 32'(op_count), 32'(8'd1));

      // XOR with red_op_B on B=7 from requester 1: legal, ^B = 1
      submit(1'b1, 16'h3788, 6'd1, 1'b0);
      drain();

      // Both requesters continuously valid: AND 6&3, MUL 3*5 vs ADD 4+2+1, XOR 6^5
      submit(1'b0, 16'h1980, 6'd2, 1'b0);
      submit(1'b0, 16'h6E80, 6'd15, 1'b0);
      submit(1'b1, 16'h5140, 6'd7, 1'b0);
      submit(1'b1, 16'h3A80, 6'd3, 1'b0);
      drain();
      base = rsp_log.size() - 4;
      chk("alt_order0", 32'(rsp_log[base]), 32'(0));
      chk("alt_order1", 32'(rsp_log[base+1]), 32'(1));
      chk("alt_order2", 32'(rsp_log[base+2]), 32'(0));
      chk("alt_order3", 32'(rsp_log[base+3]), 32'(1));

      // Illegal opcode 110, then ADD with red_op_A
      submit(1'b0, 16'hC480, 6'd0, 1'b1);
      drain();
      chk("inv_count_first", 32'(invalid_count), 32'(8'd1));
      submit(1'b1, 16'h4490, 6'd0, 1'b1);
      drain();
      chk("op_count_after_inv", 32'(op_count), 32'(8'd8));
      chk("inv_count_after_inv", 32'(invalid_count), 32'(8'd2));

      // Shift left with serial_in=1 on a zero out register
      submit(1'b0, 16'h8021, 6'd1, 1'b0);
      drain();

      // Reset during WAIT drops the command and restores the pointer
      submit(1'b0, 16'h4D00, 6'd5, 1'b0);
      n = 0;
      while (expq.size() == 0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("mid_reset_handshake", 32'(n < 50), 32'(1));
      @(posedge clk);
      apply_reset();
      submit(1'b1, 16'h3A80, 6'd3, 1'b0);
      submit(1'b0, 16'h1980, 6'd2, 1'b0);
      drain();
      base = rsp_log.size() - 2;
      chk("post_reset_first_id", 32'(rsp_log[base]), 32'(0));
      chk("post_reset_second_id", 32'(rsp_log[base+1]), 32'(1));

      // 256 invalid commands: invalid_count saturates, op_count wraps
      apply_reset();
      for (int i = 0; i < 256; i++) submit(1'b0, 16'hC480, 6'd0, 1'b1);
      drain();
      chk("wrap_op_count", 32'(op_count), 32'(8'd0));
      chk("sat_invalid_count", 32'(invalid_count), 32'(8'd255));
      chk("scoreboard_empty", 32'(expq.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
